mem_access_ctrl: RTL and testbench
==================================

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameter WAIT_CYCLES, default 1: cycles the memory strobes are held per access; values below 1 SHALL behave as 1.
REQ-002 Parameter MEM_DEPTH, default 201: number of valid data-memory words.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req_valid  input  1  pipeline presents a memory-stage request.
REQ-006 req_ready  output  1  controller can accept a request this cycle.
REQ-007 req_is_ld  input  1  request is a load.
REQ-008 req_is_st  input  1  request is a store.
REQ-009 req_addr  input  32  word address.
REQ-010 req_wdata  input  32  store data.
REQ-011 req_rd  input  4  destination register tag.
REQ-012 mem_isLd  output  1  load strobe to data memory.
REQ-013 mem_isSt  output  1  store strobe to data memory.
REQ-014 mem_address  output  32  address to data memory.
REQ-015 mem_data_in  output  32  write data to data memory.
REQ-016 mem_data_out  input  32  read data from data memory (combinational, valid while mem_isLd is high).
REQ-017 resp_valid  output  1  one-cycle completion pulse.
REQ-018 resp_data  output  32  load result (0 for stores and non-memory requests).
REQ-019 resp_rd  output  4  tag of the completed request.
REQ-020 resp_is_ld  output  1  completed request was a load.
REQ-021 stall  output  1  pipeline must hold; equals NOT req_ready.
REQ-022 fault  output  1  address out of range; qualified by resp_valid.

Function
REQ-023 FSM states: IDLE, ACCESS, DONE; req_ready SHALL be 1 only in IDLE.
REQ-024 IDLE: on req_valid at a rising edge, latch addr/wdata/rd/is_ld/is_st; go to ACCESS if is_ld or is_st, else to DONE.
REQ-025 req_is_ld and req_is_st both high: treated as store only; resp_is_ld=0.
REQ-026 ACCESS: mem_isLd/mem_isSt driven from the latched type for exactly WAIT_CYCLES cycles, tracked by a down-counter; on the last ACCESS cycle, capture mem_data_out into resp_data (loads only); then go to DONE.
REQ-027 DONE: resp_valid=1 for exactly one cycle, then return to IDLE; resp_data/resp_rd/resp_is_ld/fault stay held until the next completion.
REQ-028 Latency: request accepted at edge N; resp_valid high during cycle N+WAIT_CYCLES+1 for memory ops and during cycle N+1 for non-memory requests.
REQ-029 All mem_* outputs are registered and glitch-free; both strobes are 0 outside ACCESS; mem_address/mem_data_in are stable throughout ACCESS.
REQ-030 req_valid while not IDLE is ignored; the requester holds it until req_ready.
REQ-031 Back-to-back requests: the next request is accepted in the IDLE cycle following DONE; no overlap of strobes between requests.

Reset
REQ-032 A rising edge with reset=1 forces state IDLE and counter 0, and clears every output to 0 except req_ready=1 and stall=0.
REQ-033 Reset during ACCESS aborts the access; strobes are 0 from the reset edge onward, and no resp_valid is produced for the aborted request.

Configuration
REQ-034 Macro MA_RANGE_CHECK_EN defined: a memory request with req_addr >= MEM_DEPTH skips ACCESS (no strobes), goes to DONE, and completes with fault=1 and resp_data=0.
REQ-035 Macro MA_RANGE_CHECK_EN undefined: no range check is performed, all addresses are passed through, and fault is tied to 0.

Verification
REQ-036 Load: WAIT_CYCLES=1, model word 5 = 3; request ld addr 5, rd 2 at edge 0 -> mem_isLd high during cycle 1 only; resp_valid high during cycle 2 with resp_data=3, resp_rd=2, resp_is_ld=1.
REQ-037 Store: WAIT_CYCLES=3; st addr 10 data 0xDEADBEEF -> mem_isSt high for 3 cycles; model word 10 = 0xDEADBEEF; resp_valid high during cycle 4 with resp_data=0.
REQ-038 Back-to-back ld 1 then ld 2, req_valid held, model words 8/4 -> two resp_valid pulses with data 8 then 4; stall high while busy; strobes never overlap.
REQ-039 Reset asserted during the 2nd ACCESS cycle of a WAIT_CYCLES=3 store -> strobes 0 after the reset edge; no resp_valid; req_ready=1.
REQ-040 With MA_RANGE_CHECK_EN: ld addr 300 -> no strobe; resp_valid during cycle 1 with fault=1 and resp_data=0. Without MA_RANGE_CHECK_EN: mem_isLd is asserted and fault=0.
REQ-041 Non-memory request (ld=st=0), rd 7 -> no strobes; resp_valid during cycle 1 with resp_rd=7 and resp_data=0.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: memory-stage access controller.
// Accepts one request at a time, drives registered strobes to a data memory
// for WAIT_CYCLES cycles, then gives a one-cycle completion pulse.
// Optional feature macro: MA_RANGE_CHECK_EN (out-of-range addresses fault
// instead of reaching the memory).
module mem_access_ctrl #(
   parameter int WAIT_CYCLES = 1,
   parameter int MEM_DEPTH   = 201
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_is_ld,
   input  logic        req_is_st,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [3:0]  req_rd,
   output logic        mem_isLd,
   output logic        mem_isSt,
   output logic [31:0] mem_address,
   output logic [31:0] mem_data_in,
   input  logic [31:0] mem_data_out,
   output logic        resp_valid,
   output logic [31:0] resp_data,
   output logic [3:0]  resp_rd,
   output logic        resp_is_ld,
   output logic        stall,
   output logic        fault
);

   // A wait count below one still gives a single strobe cycle.
   localparam int WAIT_EFF = (WAIT_CYCLES < 1) ? 1 : WAIT_CYCLES;
   localparam int CNT_W    = $clog2(WAIT_EFF + 1);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_EFF);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);

   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

   state_t           r_state;
   logic [CNT_W-1:0] r_cnt;
   logic             r_is_ld;
   logic [3:0]       r_rd;
   logic             r_mem_isLd;
   logic             r_mem_isSt;
   logic [31:0]      r_mem_address;
   logic [31:0]      r_mem_data_in;
   logic             r_resp_valid;
   logic [31:0]      r_resp_data;
   logic [3:0]       r_resp_rd;
   logic             r_resp_is_ld;
   logic             r_fault;

   logic             w_is_mem;
   logic             w_eff_ld;
   logic             w_out_of_range;

   // A request with both type bits set is a store.
   assign w_is_mem = req_is_ld | req_is_st;
   assign w_eff_ld = req_is_ld & ~req_is_st;

`ifdef MA_RANGE_CHECK_EN
   localparam logic [31:0] DEPTH_W = 32'(MEM_DEPTH);
   assign w_out_of_range = w_is_mem && (req_addr >= DEPTH_W);
`else
   // Without the range check every address goes straight to the memory.
   localparam int unused_mem_depth = MEM_DEPTH;
   assign w_out_of_range = 1'b0;
`endif

   // Controller FSM: all memory and response outputs are registered here.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state       <= IDLE;
         r_cnt         <= '0;
         r_is_ld       <= 1'b0;
         r_rd          <= '0;
         r_mem_isLd    <= 1'b0;
         r_mem_isSt    <= 1'b0;
         r_mem_address <= '0;
         r_mem_data_in <= '0;
         r_resp_valid  <= 1'b0;
         r_resp_data   <= '0;
         r_resp_rd     <= '0;
         r_resp_is_ld  <= 1'b0;
         r_fault       <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               r_resp_valid <= 1'b0;
               if (req_valid) begin
                  r_rd          <= req_rd;
                  r_is_ld       <= w_eff_ld;
                  r_mem_address <= req_addr;
                  r_mem_data_in <= req_wdata;
                  if (w_is_mem && !w_out_of_range) begin
                     r_state    <= ACCESS;
                     r_cnt      <= CNT_LOAD;
                     r_mem_isLd <= w_eff_ld;
                     r_mem_isSt <= req_is_st;
                  end else begin
                     // Non-memory or faulting request completes next cycle.
                     r_state      <= DONE;
                     r_resp_valid <= 1'b1;
                     r_resp_data  <= '0;
                     r_resp_rd    <= req_rd;
                     r_resp_is_ld <= w_eff_ld;
                     r_fault      <= w_out_of_range;
                  end
               end
            end
            ACCESS: begin
               if (r_cnt == CNT_LAST) begin
                  r_mem_isLd   <= 1'b0;
                  r_mem_isSt   <= 1'b0;
                  r_cnt        <= '0;
                  r_resp_data  <= r_is_ld ? mem_data_out : 32'h0;
                  r_resp_rd    <= r_rd;
                  r_resp_is_ld <= r_is_ld;
                  r_fault      <= 1'b0;
                  r_resp_valid <= 1'b1;
                  r_state      <= DONE;
               end else begin
                  r_cnt <= r_cnt - CNT_LAST;
               end
            end
            DONE: begin
               r_resp_valid <= 1'b0;
               r_state      <= IDLE;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign req_ready   = (r_state == IDLE);
   assign stall       = ~req_ready;
   assign mem_isLd    = r_mem_isLd;
   assign mem_isSt    = r_mem_isSt;
   assign mem_address = r_mem_address;
   assign mem_data_in = r_mem_data_in;
   assign resp_valid  = r_resp_valid;
   assign resp_data   = r_resp_data;
   assign resp_rd     = r_resp_rd;
   assign resp_is_ld  = r_resp_is_ld;
   assign fault       = r_fault;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: instance a uses WAIT_CYCLES=1,
// instance b uses WAIT_CYCLES=3. Each has a small word-memory model.
module tb_mem_access_ctrl;

   logic clk;
   int   total;
   int   bad;

   // instance a (WAIT_CYCLES = 1)
   logic        a_rst, a_req_valid, a_req_ready, a_req_is_ld, a_req_is_st;
   logic [31:0] a_req_addr, a_req_wdata;
   logic [3:0]  a_req_rd;
   logic        a_mem_isLd, a_mem_isSt;
   logic [31:0] a_mem_address, a_mem_data_in, a_mem_data_out;
   logic        a_resp_valid, a_resp_is_ld, a_stall, a_fault;
   logic [31:0] a_resp_data;
   logic [3:0]  a_resp_rd;

   // instance b (WAIT_CYCLES = 3)
   logic        b_rst, b_req_valid, b_req_ready, b_req_is_ld, b_req_is_st;
   logic [31:0] b_req_addr, b_req_wdata;
   logic [3:0]  b_req_rd;
   logic        b_mem_isLd, b_mem_isSt;
   logic [31:0] b_mem_address, b_mem_data_in, b_mem_data_out;
   logic        b_resp_valid, b_resp_is_ld, b_stall, b_fault;
   logic [31:0] b_resp_data;
   logic [3:0]  b_resp_rd;

   // memory models
   logic [31:0] mem_a [0:255];
   logic [31:0] mem_b [0:255];
   logic        a_pl_we;
   logic [7:0]  a_pl_addr;
   logic [31:0] a_pl_data;

   mem_access_ctrl #(.WAIT_CYCLES(1), .MEM_DEPTH(201)) u_dut_a (
      .clk(clk), .reset(a_rst),
      .req_valid(a_req_valid), .req_ready(a_req_ready),
      .req_is_ld(a_req_is_ld), .req_is_st(a_req_is_st),
      .req_addr(a_req_addr), .req_wdata(a_req_wdata), .req_rd(a_req_rd),
      .mem_isLd(a_mem_isLd), .mem_isSt(a_mem_isSt),
      .mem_address(a_mem_address), .mem_data_in(a_mem_data_in),
      .mem_data_out(a_mem_data_out),
      .resp_valid(a_resp_valid), .resp_data(a_resp_data),
      .resp_rd(a_resp_rd), .resp_is_ld(a_resp_is_ld),
      .stall(a_stall), .fault(a_fault)
   );

   mem_access_ctrl #(.WAIT_CYCLES(3), .MEM_DEPTH(201)) u_dut_b (
      .clk(clk), .reset(b_rst),
      .req_valid(b_req_valid), .req_ready(b_req_ready),
      .req_is_ld(b_req_is_ld), .req_is_st(b_req_is_st),
      .req_addr(b_req_addr), .req_wdata(b_req_wdata), .req_rd(b_req_rd),
      .mem_isLd(b_mem_isLd), .mem_isSt(b_mem_isSt),
      .mem_address(b_mem_address), .mem_data_in(b_mem_data_in),
      .mem_data_out(b_mem_data_out),
      .resp_valid(b_resp_valid), .resp_data(b_resp_data),
      .resp_rd(b_resp_rd), .resp_is_ld(b_resp_is_ld),
      .stall(b_stall), .fault(b_fault)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign a_mem_data_out = mem_a[a_mem_address[7:0]];
   assign b_mem_data_out = mem_b[b_mem_address[7:0]];

   always @(posedge clk) begin
      if (a_pl_we) mem_a[a_pl_addr] <= a_pl_data;
      else if (a_mem_isSt) mem_a[a_mem_address[7:0]] <= a_mem_data_in;
   end

   always @(posedge clk) begin
      if (b_mem_isSt) mem_b[b_mem_address[7:0]] <= b_mem_data_in;
   end

   // Present a request at the current negedge for one edge; returns at the
   // negedge of cycle 1 (the cycle after the accepting edge).
   task a_issue(input logic ld, input logic st, input logic [31:0] addr,
                input logic [31:0] wd, input logic [3:0] rd);
      a_req_is_ld = ld; a_req_is_st = st; a_req_addr = addr;
      a_req_wdata = wd; a_req_rd = rd; a_req_valid = 1'b1;
      $display("txn a: ld=%0b st=%0b addr=%0d wdata=%h rd=%0d", ld, st, addr, wd, rd);
      @(negedge clk);
      a_req_valid = 1'b0;
   endtask

   task b_issue(input logic ld, input logic st, input logic [31:0] addr,
                input logic [31:0] wd, input logic [3:0] rd);
      b_req_is_ld = ld; b_req_is_st = st; b_req_addr = addr;
      b_req_wdata = wd; b_req_rd = rd; b_req_valid = 1'b1;
      $display("txn b: ld=%0b st=%0b addr=%0d wdata=%h rd=%0d", ld, st, addr, wd, rd);
      @(negedge clk);
      b_req_valid = 1'b0;
   endtask

   task preload_all();
      logic [7:0]  pa [6];
      logic [31:0] pd [6];
      pa[0] = 8'd5;   pd[0] = 32'd3;
      pa[1] = 8'd1;   pd[1] = 32'd8;
      pa[2] = 8'd2;   pd[2] = 32'd4;
      pa[3] = 8'd44;  pd[3] = 32'h77;
      pa[4] = 8'd200; pd[4] = 32'hC8;
      pa[5] = 8'd201; pd[5] = 32'hC9;
      for (int i = 0; i < 6; i++) begin
         a_pl_we = 1'b1; a_pl_addr = pa[i]; a_pl_data = pd[i];
         @(negedge clk);
      end
      a_pl_we = 1'b0;
   endtask

   task test_reset();
      a_rst = 1'b1; b_rst = 1'b1;
      @(negedge clk); @(negedge clk);
      $display("txn reset asserted");
      total++; if (a_req_ready !== 1'b1) begin bad++; $display("FAIL rst_ready got=%b exp=1", a_req_ready); end
      total++; if (a_stall !== 1'b0) begin bad++; $display("FAIL rst_stall got=%b exp=0", a_stall); end
      total++; if ({a_mem_isLd, a_mem_isSt, a_resp_valid, a_fault, a_resp_is_ld} !== 5'b0) begin bad++; $display("FAIL rst_flags got=%b exp=00000", {a_mem_isLd, a_mem_isSt, a_resp_valid, a_fault, a_resp_is_ld}); end
      total++; if ({a_mem_address, a_mem_data_in, a_resp_data, a_resp_rd} !== 100'b0) begin bad++; $display("FAIL rst_buses got=%h exp=0", {a_mem_address, a_mem_data_in, a_resp_data, a_resp_rd}); end
      total++; if ({b_req_ready, b_stall, b_mem_isSt, b_resp_valid} !== 4'b1000) begin bad++; $display("FAIL rst_b got=%b exp=1000", {b_req_ready, b_stall, b_mem_isSt, b_resp_valid}); end
      a_rst = 1'b0; b_rst = 1'b0;
      @(negedge clk);
      total++; if (a_req_ready !== 1'b1 || a_resp_valid !== 1'b0) begin bad++; $display("FAIL post_rst_idle got=%b%b exp=10", a_req_ready, a_resp_valid); end
   endtask

   task test_load();
      a_issue(1'b1, 1'b0, 32'd5, 32'h0, 4'd2);
      total++; if (a_mem_isLd !== 1'b1 || a_mem_isSt !== 1'b0) begin bad++; $display("FAIL ld_c1_strobe got=%b%b exp=10", a_mem_isLd, a_mem_isSt); end
      total++; if (a_mem_address !== 32'd5) begin bad++; $display("FAIL ld_c1_addr got=%0d exp=5", a_mem_address); end
      total++; if (a_stall !== 1'b1 || a_resp_valid !== 1'b0) begin bad++; $display("FAIL ld_c1_stall got=%b%b exp=10", a_stall, a_resp_valid); end
      @(negedge clk);
      total++; if (a_mem_isLd !== 1'b0) begin bad++; $display("FAIL ld_c2_strobe got=%b exp=0", a_mem_isLd); end
      total++; if (a_resp_valid !== 1'b1) begin bad++; $display("FAIL ld_c2_valid got=%b exp=1", a_resp_valid); end
      total++; if (a_resp_data !== 32'd3) begin bad++; $display("FAIL ld_c2_data got=%h exp=3", a_resp_data); end
      total++; if (a_resp_rd !== 4'd2 || a_resp_is_ld !== 1'b1 || a_fault !== 1'b0) begin bad++; $display("FAIL ld_c2_tag got=%0d/%b/%b exp=2/1/0", a_resp_rd, a_resp_is_ld, a_fault); end
      @(negedge clk);
      total++; if (a_resp_valid !== 1'b0 || a_req_ready !== 1'b1) begin bad++; $display("FAIL ld_c3_idle got=%b%b exp=01", a_resp_valid, a_req_ready); end
      total++; if (a_resp_data !== 32'd3) begin bad++; $display("FAIL ld_c3_hold got=%h exp=3", a_resp_data); end
   endtask

   task test_store();
      b_issue(1'b0, 1'b1, 32'd10, 32'hDEADBEEF, 4'd1);
      for (int c = 1; c <= 3; c++) begin
         total++; if (b_mem_isSt !== 1'b1 || b_mem_isLd !== 1'b0) begin bad++; $display("FAIL st_c%0d_strobe got=%b%b exp=01", c, b_mem_isLd, b_mem_isSt); end
         total++; if (b_mem_address !== 32'd10 || b_mem_data_in !== 32'hDEADBEEF) begin bad++; $display("FAIL st_c%0d_bus got=%0d/%h exp=10/deadbeef", c, b_mem_address, b_mem_data_in); end
         total++; if (b_resp_valid !== 1'b0) begin bad++; $display("FAIL st_c%0d_early got=%b exp=0", c, b_resp_valid); end
         @(negedge clk);
      end
      total++; if (b_mem_isSt !== 1'b0 || b_resp_valid !== 1'b1) begin bad++; $display("FAIL st_c4 got=%b%b exp=01", b_mem_isSt, b_resp_valid); end
      total++; if (b_resp_data !== 32'h0 || b_resp_is_ld !== 1'b0 || b_resp_rd !== 4'd1) begin bad++; $display("FAIL st_c4_resp got=%h/%b/%0d exp=0/0/1", b_resp_data, b_resp_is_ld, b_resp_rd); end
      total++; if (mem_b[10] !== 32'hDEADBEEF) begin bad++; $display("FAIL st_mem got=%h exp=deadbeef", mem_b[10]); end
      @(negedge clk);
      total++; if (b_resp_valid !== 1'b0 || b_req_ready !== 1'b1) begin bad++; $display("FAIL st_c5 got=%b%b exp=01", b_resp_valid, b_req_ready); end
   endtask

   task test_ld_st_both();
      a_issue(1'b1, 1'b1, 32'd20, 32'h55, 4'd9);
      total++; if (a_mem_isSt !== 1'b1 || a_mem_isLd !== 1'b0) begin bad++; $display("FAIL both_strobe got=%b%b exp=01", a_mem_isLd, a_mem_isSt); end
      @(negedge clk);
      total++; if (a_resp_valid !== 1'b1 || a_resp_is_ld !== 1'b0 || a_resp_data !== 32'h0) begin bad++; $display("FAIL both_resp got=%b/%b/%h exp=1/0/0", a_resp_valid, a_resp_is_ld, a_resp_data); end
      total++; if (mem_a[20] !== 32'h55) begin bad++; $display("FAIL both_mem got=%h exp=55", mem_a[20]); end
      @(negedge clk);
   endtask

   task test_back_to_back();
      int          acc, nresp, nld, novl;
      int          rcyc [2];
      logic [31:0] rdat [2];
      logic [3:0]  rrd  [2];
      logic [7:0]  exp_stall;
      logic        take;
      acc = 0; nresp = 0; nld = 0; novl = 0;
      rcyc[0] = -1; rcyc[1] = -1; rdat[0] = '0; rdat[1] = '0; rrd[0] = '0; rrd[1] = '0;
      exp_stall = 8'b0011_0110;
      a_req_is_ld = 1'b1; a_req_is_st = 1'b0; a_req_addr = 32'd1; a_req_rd = 4'd3;
      a_req_wdata = 32'h0; a_req_valid = 1'b1;
      $display("txn a: back-to-back ld 1 then ld 2, req_valid held");
      for (int c = 0; c < 8; c++) begin
         if (a_mem_isLd === 1'b1) nld++;
         if (a_mem_isLd === 1'b1 && a_mem_isSt === 1'b1) novl++;
         total++; if (a_stall !== exp_stall[c] || a_req_ready !== ~exp_stall[c]) begin bad++; $display("FAIL b2b_stall_c%0d got=%b/%b exp=%b", c, a_stall, a_req_ready, exp_stall[c]); end
         if (a_resp_valid === 1'b1) begin
            if (nresp < 2) begin rdat[nresp] = a_resp_data; rrd[nresp] = a_resp_rd; rcyc[nresp] = c; end
            nresp++;
         end
         take = a_req_ready & a_req_valid;
         @(negedge clk);
         if (take) begin
            acc++;
            if (acc == 1) begin a_req_addr = 32'd2; a_req_rd = 4'd4; end
            else a_req_valid = 1'b0;
         end
      end
      a_req_valid = 1'b0;
      total++; if (nresp !== 2) begin bad++; $display("FAIL b2b_npulse got=%0d exp=2", nresp); end
      total++; if (rdat[0] !== 32'd8 || rdat[1] !== 32'd4) begin bad++; $display("FAIL b2b_data got=%0d,%0d exp=8,4", rdat[0], rdat[1]); end
      total++; if (rrd[0] !== 4'd3 || rrd[1] !== 4'd4) begin bad++; $display("FAIL b2b_rd got=%0d,%0d exp=3,4", rrd[0], rrd[1]); end
      total++; if (rcyc[0] !== 2 || rcyc[1] !== 5) begin bad++; $display("FAIL b2b_timing got=%0d,%0d exp=2,5", rcyc[0], rcyc[1]); end
      total++; if (nld !== 2 || novl !== 0) begin bad++; $display("FAIL b2b_strobes got=%0d/%0d exp=2/0", nld, novl); end
   endtask

   task test_reset_abort();
      int nresp, nstb;
      nresp = 0; nstb = 0;
      b_issue(1'b0, 1'b1, 32'd30, 32'h1234, 4'd6);
      total++; if (b_mem_isSt !== 1'b1) begin bad++; $display("FAIL abort_c1 got=%b exp=1", b_mem_isSt); end
      @(negedge clk);
      total++; if (b_mem_isSt !== 1'b1) begin bad++; $display("FAIL abort_c2 got=%b exp=1", b_mem_isSt); end
      b_rst = 1'b1;
      $display("txn b: reset during access");
      @(negedge clk);
      total++; if (b_mem_isSt !== 1'b0 || b_mem_isLd !== 1'b0) begin bad++; $display("FAIL abort_strobe got=%b%b exp=00", b_mem_isLd, b_mem_isSt); end
      total++; if (b_req_ready !== 1'b1 || b_stall !== 1'b0 || b_resp_valid !== 1'b0) begin bad++; $display("FAIL abort_state got=%b%b%b exp=100", b_req_ready, b_stall, b_resp_valid); end
      b_rst = 1'b0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (b_resp_valid === 1'b1) nresp++;
         if (b_mem_isSt === 1'b1 || b_mem_isLd === 1'b1) nstb++;
      end
      total++; if (nresp !== 0 || nstb !== 0) begin bad++; $display("FAIL abort_after got=%0d/%0d exp=0/0", nresp, nstb); end
      total++; if (b_req_ready !== 1'b1) begin bad++; $display("FAIL abort_ready got=%b exp=1", b_req_ready); end
   endtask

   task test_range();
      logic [31:0] addrs [3];
      logic [31:0] dats  [3];
      logic        oor;
      addrs[0] = 32'd200; dats[0] = 32'hC8;
      addrs[1] = 32'd201; dats[1] = 32'hC9;
      addrs[2] = 32'd300; dats[2] = 32'h77;
      for (int i = 0; i < 3; i++) begin
`ifdef MA_RANGE_CHECK_EN
         oor = (addrs[i] >= 32'd201);
`else
         oor = 1'b0;
`endif
         a_issue(1'b1, 1'b0, addrs[i], 32'h0, 4'd5);
         if (oor) begin
            total++; if (a_mem_isLd !== 1'b0 || a_resp_valid !== 1'b1) begin bad++; $display("FAIL rng%0d_skip got=%b%b exp=01", i, a_mem_isLd, a_resp_valid); end
            total++; if (a_fault !== 1'b1 || a_resp_data !== 32'h0) begin bad++; $display("FAIL rng%0d_fault got=%b/%h exp=1/0", i, a_fault, a_resp_data); end
            @(negedge clk);
         end else begin
            total++; if (a_mem_isLd !== 1'b1 || a_resp_valid !== 1'b0) begin bad++; $display("FAIL rng%0d_strobe got=%b%b exp=10", i, a_mem_isLd, a_resp_valid); end
            @(negedge clk);
            total++; if (a_resp_valid !== 1'b1 || a_fault !== 1'b0 || a_resp_data !== dats[i]) begin bad++; $display("FAIL rng%0d_resp got=%b/%b/%h exp=1/0/%h", i, a_resp_valid, a_fault, a_resp_data, dats[i]); end
            @(negedge clk);
         end
         total++; if (a_resp_valid !== 1'b0 || a_req_ready !== 1'b1) begin bad++; $display("FAIL rng%0d_idle got=%b%b exp=01", i, a_resp_valid, a_req_ready); end
      end
   endtask

   task test_nonmem();
      a_issue(1'b0, 1'b0, 32'd7, 32'hFFFF, 4'd7);
      total++; if (a_mem_isLd !== 1'b0 || a_mem_isSt !== 1'b0) begin bad++; $display("FAIL nm_strobe got=%b%b exp=00", a_mem_isLd, a_mem_isSt); end
      total++; if (a_resp_valid !== 1'b1 || a_resp_rd !== 4'd7 || a_resp_data !== 32'h0) begin bad++; $display("FAIL nm_resp got=%b/%0d/%h exp=1/7/0", a_resp_valid, a_resp_rd, a_resp_data); end
      total++; if (a_resp_is_ld !== 1'b0 || a_fault !== 1'b0) begin bad++; $display("FAIL nm_flags got=%b%b exp=00", a_resp_is_ld, a_fault); end
      @(negedge clk);
      total++; if (a_resp_valid !== 1'b0 || a_req_ready !== 1'b1) begin bad++; $display("FAIL nm_idle got=%b%b exp=01", a_resp_valid, a_req_ready); end
   endtask

   initial begin
      total = 0; bad = 0;
      a_rst = 1'b1; b_rst = 1'b1;
      a_req_valid = 1'b0; a_req_is_ld = 1'b0; a_req_is_st = 1'b0;
      a_req_addr = '0; a_req_wdata = '0; a_req_rd = '0;
      b_req_valid = 1'b0; b_req_is_ld = 1'b0; b_req_is_st = 1'b0;
      b_req_addr = '0; b_req_wdata = '0; b_req_rd = '0;
      a_pl_we = 1'b0; a_pl_addr = '0; a_pl_data = '0;
      @(negedge clk);
      test_reset();
      preload_all();
      test_load();
      test_store();
      test_ld_st_both();
      test_back_to_back();
      test_reset_abort();
      test_range();
      test_nonmem();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Absolute time limit so the run always ends.
   initial begin
      #200000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1, "time limit");
   end

endmodule
